// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the bit-serial ALU.
package alu_pkg;

  localparam logic [2:0] OpAdd  = 3'd0;
  localparam logic [2:0] OpAnd  = 3'd1;
  localparam logic [2:0] OpOr   = 3'd2;
  localparam logic [2:0] OpXor  = 3'd3;
  localparam logic [2:0] OpXnor = 3'd4;
  localparam logic [2:0] OpSub  = 3'd5;

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_t;

  // Opcodes 6 and 7 have no defined operation.
  function automatic logic is_reserved(input logic [2:0] op);
    return op > OpSub;
  endfunction

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OpAdd) || (op == OpSub);
  endfunction

endpackage

// File: rtl/alu_slice.sv
// One DIGIT-bit slice of the ALU datapath; purely combinational.
module alu_slice
  import alu_pkg::*;
#(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  input  logic [2:0]       op,
  output logic [DIGIT-1:0] sum,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT-1:0] bx;
  logic             c;

  // Ripple through the slice for ADD/SUB; logic ops never produce a carry.
  always_comb begin
    sum   = '0;
    co    = 1'b0;
    c_msb = 1'b0;
    c     = ci;
    bx    = (op == OpSub) ? ~b : b;
    case (op)
      OpAdd, OpSub: begin
        for (int i = 0; i < int'(DIGIT); i++) begin
          if (i == int'(DIGIT) - 1) c_msb = c;
          sum[i] = a[i] ^ bx[i] ^ c;
          c      = (a[i] & bx[i]) | (c & (a[i] ^ bx[i]));
        end
        co = c;
      end
      OpAnd:   sum = a & b;
      OpOr:    sum = a | b;
      OpXor:   sum = a ^ b;
      OpXnor:  sum = ~(a ^ b);
      default: sum = '0;
    endcase
  end

endmodule

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: processes DIGIT bits per cycle, LSB first, over WIDTH/DIGIT cycles.
module bit_serial_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [2:0]       M,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] X,
  output logic             Co,
  output logic             Z,
  output logic             V,
  output logic             ERR
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q, x_q;
  logic [2:0]       op_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q, co_q, z_q, v_q, err_q;

  logic [DIGIT-1:0] slice_sum;
  logic             slice_co, slice_cmsb;
  logic [WIDTH-1:0] res_next;
  logic             accept, last;

  assign accept = START && (state_q != StRun);
  assign last   = (cnt_q == CntW'(N - 1));
  // New slice enters at the top; after N shifts the first slice sits at bit 0.
  assign res_next = (res_q >> DIGIT) | (WIDTH'(slice_sum) << (WIDTH - DIGIT));

  alu_slice #(
    .DIGIT(DIGIT)
  ) u_slice (
    .a    (a_q[DIGIT-1:0]),
    .b    (b_q[DIGIT-1:0]),
    .ci   (carry_q),
    .op   (op_q),
    .sum  (slice_sum),
    .co   (slice_co),
    .c_msb(slice_cmsb)
  );

  // Next-state logic; START is only honoured outside RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (last) state_d = StFin;
      StFin:   state_d = accept ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Operand capture, serial shifting and result/flag latching on the final slice.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= OpAdd;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      x_q     <= '0;
      co_q    <= 1'b0;
      z_q     <= 1'b1;
      v_q     <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= A;
      b_q     <= B;
      op_q    <= M;
      cnt_q   <= '0;
      carry_q <= (M == OpSub) ? 1'b1 : ((M == OpAdd) ? CI : 1'b0);
      err_q   <= 1'b0;
    end else if (state_q == StRun) begin
      a_q     <= a_q >> DIGIT;
      b_q     <= b_q >> DIGIT;
      res_q   <= res_next;
      carry_q <= slice_co;
      cnt_q   <= cnt_q + CntW'(1);
      if (last) begin
        x_q   <= res_next;
        co_q  <= slice_co;
        z_q   <= (res_next == '0);
        v_q   <= is_arith(op_q) ? (slice_cmsb ^ slice_co) : 1'b0;
        err_q <= is_reserved(op_q);
      end
    end
  end

  assign BUSY = (state_q == StRun);
  assign DONE = (state_q == StFin);
  assign X    = x_q;
  assign Co   = co_q;
  assign Z    = z_q;
  assign V    = v_q;
  assign ERR  = err_q;

endmodule

// File: doc/bit_serial_alu.md
BIT_SERIAL_ALU -- requirements
Module: bit_serial_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; SHALL be >= 2.
REQ-002 Parameter DIGIT, default 1, bits processed per cycle; SHALL divide WIDTH exactly. N = WIDTH/DIGIT.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 START  input  1  request to begin one operation on A, B, M, CI.
REQ-006 M  input  3  opcode: 0 ADD, 1 AND, 2 OR, 3 XOR, 4 XNOR, 5 SUB (A-B); 6 and 7 reserved.
REQ-007 A, B  input  WIDTH  operands, sampled only when START is accepted.
REQ-008 CI  input  1  carry-in, used by ADD only.
REQ-009 BUSY  output  1  high while an operation is in progress.
REQ-010 DONE  output  1  one-cycle pulse; X and flags are valid while it is high.
REQ-011 X  output  WIDTH  result.
REQ-012 Co  output  1  carry-out (ADD) or no-borrow (SUB); 0 for every other opcode.
REQ-013 Z  output  1  high when X == 0.
REQ-014 V  output  1  signed overflow (ADD/SUB); 0 otherwise.
REQ-015 ERR  output  1  high when the completed operation used a reserved opcode.

Function
REQ-016 FSM states: IDLE, RUN, FIN. Only RUN asserts BUSY; only FIN asserts DONE.
REQ-017 START is accepted in IDLE or FIN. On acceptance: A, B, M, CI are captured, the digit counter is cleared, and the next state is RUN.
REQ-018 START is ignored in RUN; a captured operation SHALL NOT be disturbed by input changes.
REQ-019 RUN processes one DIGIT-bit slice per cycle, LSB first, for exactly N cycles, then moves to FIN. FIN lasts one cycle, then moves to IDLE unless START is accepted.
REQ-020 Latency: when START is accepted at edge t, DONE is high from edge t+N to edge t+N+1. Back-to-back throughput is N+1 cycles.
REQ-021 ADD: the carry chain is seeded with CI. SUB: B is inverted and the chain is seeded with 1. AND/OR/XOR/XNOR: the carry is forced to 0 and does not propagate.
REQ-022 The carry SHALL propagate between slices through a carry register. Co is the carry out of the final slice.
REQ-023 V = carry into the MSB XOR carry out of the MSB, for ADD/SUB only.
REQ-024 Reserved opcodes: X = 0, Co = 0, V = 0, Z = 1, ERR = 1 at DONE. ERR is cleared on the next accepted START.
REQ-025 X, Co, Z, V and ERR SHALL hold their FIN values until the next START is accepted. Intermediate X values during RUN are unspecified.

Reset
REQ-026 RST high SHALL immediately force state IDLE, counter 0, carry register 0, and BUSY = DONE = 0, X = 0, Co = 0, Z = 1, V = 0, ERR = 0.
REQ-027 RST asserted mid-operation aborts the operation with no DONE pulse. START SHALL be accepted on the first rising edge after RST deasserts.

Structure
REQ-028 A shared package alu_pkg SHALL hold the opcode encoding constants and the FSM state type.
REQ-029 A combinational sub-module alu_slice (DIGIT bits wide; inputs a, b, ci, op; outputs sum, co, and carry-into-MSB) SHALL implement one digit. bit_serial_alu instantiates it once.

Verification (WIDTH=8, DIGIT=1 unless stated)
REQ-030 ADD A=0xFF, B=0x01, CI=0 -> at DONE: X=0x00, Co=1, Z=1, V=0; DONE exactly 8 edges after the accepting edge.
REQ-031 SUB A=0x80, B=0x01 -> X=0x7F, Co=1, V=1, Z=0. SUB A=0x00, B=0x01 -> X=0xFF, Co=0, V=0.
REQ-032 XNOR A=0xA5, B=0x0F -> X=0x55, Co=0, V=0. Then START with M=6 -> X=0x00, Z=1, ERR=1.
REQ-033 START pulsed again at RUN cycle 3 with different operands -> ignored; first result unchanged. START held during FIN -> a second operation completes 9 cycles after the first DONE.
REQ-034 RST asserted at RUN cycle 4 -> outputs at reset values within the same cycle and no DONE pulse. A new ADD 0x12+0x34 issued after reset -> X=0x46.
REQ-035 WIDTH=8, DIGIT=4: ADD 0x7F+0x01 -> X=0x80, V=1, Co=0; DONE 2 edges after acceptance.
